// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/stall sequencer.
// master = pipeline datapath, slave = hazard_stall_ctrl.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             fwd_en;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       exe_dest;
  logic             mem_wb_en;
  logic [3:0]       mem_dest;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_freeze;
  logic             if_id_freeze;
  logic             if_id_flush;
  logic             id_ex_freeze;
  logic             id_ex_flush;
  logic             ex_mem_freeze;
  logic             mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;

  modport master (
    output fwd_en, id_src1, id_src2, id_two_src, exe_wb_en, exe_mem_r_en,
           exe_dest, mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready,
    input  pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
           ex_mem_freeze, mem_wb_flush, stall_cnt, mem_timeout
  );

  modport slave (
    input  fwd_en, id_src1, id_src2, id_two_src, exe_wb_en, exe_mem_r_en,
           exe_dest, mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready,
    output pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
           ex_mem_freeze, mem_wb_flush, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Freeze/flush sequencer for the 5-stage core: memory wait states, branch squash
// and RAW interlock, plus a saturating stall counter and sticky memory-timeout flag.
module hazard_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_timeout_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic mem_stall_s;
  logic src1_exe_s;
  logic src1_mem_s;
  logic src2_exe_s;
  logic src2_mem_s;
  logic hz1_s;
  logic hz2_s;
  logic raw_nofwd_s;
  logic raw_fwd_s;
  logic raw_s;

  logic pc_freeze_s;
  logic if_id_freeze_s;
  logic if_id_flush_s;
  logic id_ex_freeze_s;
  logic id_ex_flush_s;
  logic ex_mem_freeze_s;
  logic mem_wb_flush_s;

  assign mem_stall_s = bus.mem_req & ~bus.mem_ready;

  assign src1_exe_s = (bus.id_src1 == bus.exe_dest) & bus.exe_wb_en;
  assign src1_mem_s = (bus.id_src1 == bus.mem_dest) & bus.mem_wb_en;
  assign src2_exe_s = (bus.id_src2 == bus.exe_dest) & bus.exe_wb_en;
  assign src2_mem_s = (bus.id_src2 == bus.mem_dest) & bus.mem_wb_en;

  assign hz1_s       = src1_exe_s | src1_mem_s;
  assign hz2_s       = bus.id_two_src & (src2_exe_s | src2_mem_s);
  assign raw_nofwd_s = hz1_s | hz2_s;
  // With forwarding only a load in EXE cannot be bypassed in time.
  assign raw_fwd_s   = bus.exe_mem_r_en & (src1_exe_s | (bus.id_two_src & src2_exe_s));
  assign raw_s       = bus.fwd_en ? raw_fwd_s : raw_nofwd_s;

  // Prioritised freeze/flush decode; reset forces every control low at once.
  always_comb begin
    pc_freeze_s     = 1'b0;
    if_id_freeze_s  = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_freeze_s  = 1'b0;
    id_ex_flush_s   = 1'b0;
    ex_mem_freeze_s = 1'b0;
    mem_wb_flush_s  = 1'b0;
    if (rst) begin
      pc_freeze_s = 1'b0;
    end else if (mem_stall_s) begin
      pc_freeze_s     = 1'b1;
      if_id_freeze_s  = 1'b1;
      id_ex_freeze_s  = 1'b1;
      ex_mem_freeze_s = 1'b1;
      mem_wb_flush_s  = 1'b1;
    end else if (bus.branch_taken) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (raw_s) begin
      pc_freeze_s    = 1'b1;
      if_id_freeze_s = 1'b1;
      id_ex_flush_s  = 1'b1;
    end else begin
      pc_freeze_s = 1'b0;
    end
  end

  // Memory wait-state FSM with wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          wait_cnt_r <= {WAIT_W{1'b0}};
          if (mem_stall_s) begin
            state_r <= MEM_WAIT;
          end else begin
            state_r <= RUN;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
          if (mem_stall_s && (wait_cnt_r == WAIT_LAST)) begin
            mem_timeout_r <= 1'b1;
          end else begin
            mem_timeout_r <= mem_timeout_r;
          end
          // A dropped request is illegal here; recover to RUN rather than hang.
          if (!bus.mem_req || bus.mem_ready) begin
            state_r <= RUN;
          end else begin
            state_r <= MEM_WAIT;
          end
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (pc_freeze_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.pc_freeze     = pc_freeze_s;
  assign bus.if_id_freeze  = if_id_freeze_s;
  assign bus.if_id_flush   = if_id_flush_s;
  assign bus.id_ex_freeze  = id_ex_freeze_s;
  assign bus.id_ex_flush   = id_ex_flush_s;
  assign bus.ex_mem_freeze = ex_mem_freeze_s;
  assign bus.mem_wb_flush  = mem_wb_flush_s;
  assign bus.stall_cnt     = stall_cnt_r;
  assign bus.mem_timeout   = mem_timeout_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed vectors push expected
// responses; a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;

  // Output order: pc_frz, ifid_frz, ifid_fl, idex_frz, idex_fl, exmem_frz, memwb_fl
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_MEMS = 7'b1101011;
  localparam logic [6:0] O_BR   = 7'b0010100;
  localparam logic [6:0] O_RAW  = 7'b1100100;

  typedef struct packed {
    logic [6:0]       o;
    logic [CNT_W-1:0] cnt;
    logic             to;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   mon_idx;
  logic [CNT_W-1:0] cnt_model;
  exp_t q[$];
  exp_t mon_e;
  logic [6:0] got_o;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic fwd, input logic [3:0] s1,
                       input logic [3:0] s2, input logic two, input logic ewb,
                       input logic emr, input logic [3:0] ed, input logic mwb,
                       input logic [3:0] md, input logic br, input logic mreq,
                       input logic mrdy, input logic [6:0] eo, input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.fwd_en       = fwd;
    bus.id_src1      = s1;
    bus.id_src2      = s2;
    bus.id_two_src   = two;
    bus.exe_wb_en    = ewb;
    bus.exe_mem_r_en = emr;
    bus.exe_dest     = ed;
    bus.mem_wb_en    = mwb;
    bus.mem_dest     = md;
    bus.branch_taken = br;
    bus.mem_req      = mreq;
    bus.mem_ready    = mrdy;
    if (r) cnt_model = '0;
    e.o   = eo;
    e.cnt = cnt_model;
    e.to  = eto;
    q.push_back(e);
    if (!r && eo[6] && (cnt_model != {CNT_W{1'b1}})) cnt_model = cnt_model + 1'b1;
  endtask

  // Monitor: compare each queued expectation at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      got_o = {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush, bus.id_ex_freeze,
               bus.id_ex_flush, bus.ex_mem_freeze, bus.mem_wb_flush};
      checks = checks + 3;
      if (got_o !== mon_e.o) begin
        errors = errors + 1;
        $display("FAIL step%0d outs got=%b exp=%b", mon_idx, got_o, mon_e.o);
      end
      if (bus.stall_cnt !== mon_e.cnt) begin
        errors = errors + 1;
        $display("FAIL step%0d stall_cnt got=%0d exp=%0d", mon_idx, bus.stall_cnt, mon_e.cnt);
      end
      if (bus.mem_timeout !== mon_e.to) begin
        errors = errors + 1;
        $display("FAIL step%0d mem_timeout got=%b exp=%b", mon_idx, bus.mem_timeout, mon_e.to);
      end
      mon_idx = mon_idx + 1;
    end
  end

  initial begin
    int drain;
    checks    = 0;
    errors    = 0;
    mon_idx   = 0;
    cnt_model = '0;
    rst       = 1'b1;
    bus.fwd_en = 1'b0; bus.id_src1 = 4'd0; bus.id_src2 = 4'd0; bus.id_two_src = 1'b0;
    bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0; bus.exe_dest = 4'd0;
    bus.mem_wb_en = 1'b0; bus.mem_dest = 4'd0; bus.branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b1;

    // Reset holds outputs low even with a memory stall pending
    drive(1, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0, O_NONE, 0);
    // No forwarding: Rn matches EXE dest
    drive(0, 0, 4'd3, 4'd0, 0, 1, 0, 4'd3, 0, 4'd0, 0, 0, 1, O_RAW, 0);
    drive(0, 0, 4'd3, 4'd0, 0, 1, 0, 4'd3, 0, 4'd0, 0, 0, 1, O_RAW, 0);
    // Forwarding: only a load in EXE stalls
    drive(0, 1, 4'd3, 4'd0, 0, 1, 0, 4'd3, 0, 4'd0, 0, 0, 1, O_NONE, 0);
    drive(0, 1, 4'd3, 4'd0, 0, 1, 1, 4'd3, 0, 4'd0, 0, 0, 1, O_RAW, 0);
    // src2 vs MEM dest, gated by id_two_src
    drive(0, 0, 4'd0, 4'd5, 0, 0, 0, 4'd0, 1, 4'd5, 0, 0, 1, O_NONE, 0);
    drive(0, 0, 4'd0, 4'd5, 1, 0, 0, 4'd0, 1, 4'd5, 0, 0, 1, O_RAW, 0);
    drive(0, 1, 4'd0, 4'd5, 1, 0, 0, 4'd0, 1, 4'd5, 0, 0, 1, O_NONE, 0);
    // Branch beats RAW
    drive(0, 0, 4'd3, 4'd0, 0, 1, 0, 4'd3, 0, 4'd0, 1, 0, 1, O_BR, 0);
    // Memory wait 3 cycles with pending branch, then flush on ready
    for (int i = 0; i < 3; i++)
      drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 1, 1, 0, O_MEMS, 0);
    drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 1, 1, 1, O_BR, 0);
    drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 1, O_NONE, 0);
    // Held wait: timeout after 4th MEM_WAIT cycle; stall_cnt saturates
    for (int i = 0; i < 10; i++)
      drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0, O_MEMS, (i >= 5) ? 1'b1 : 1'b0);
    drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 1, O_NONE, 1);
    drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0, O_MEMS, 1);
    // Async reset asserted mid-stall
    drive(1, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0, O_NONE, 0);
    drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, O_NONE, 0);
    drive(0, 0, 4'd7, 4'd0, 0, 1, 0, 4'd7, 0, 4'd0, 0, 0, 1, O_RAW, 0);
    drive(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, O_NONE, 0);

    drain = 0;
    while ((q.size() > 0) && (drain < 5)) begin
      @(posedge clk);
      drain = drain + 1;
    end
    if (q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
